// File: rtl/platform_manager.sv
// Platform pool between jumplogic and color_mapper: per-frame landing test, world
// scroll with respawn at the top, per-pixel platform hit and a saturating climb score.
module platform_manager #(
    parameter int          NUM_PLAT    = 8,
    parameter int          PLAT_W      = 64,
    parameter int          PLAT_H      = 8,
    parameter int          SCROLL_LINE = 160,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DoodleX,
    input  logic [9:0]  DoodleY,
    input  logic [9:0]  DoodleS,
    input  logic [9:0]  DoodleVY,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        plat_pixel,
    output logic        land,
    output logic [9:0]  land_y,
    output logic [9:0]  scroll_amt,
    output logic [15:0] score,
    output logic        busy
);
    localparam int          IW     = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [10:0] X_SPAN = 11'(SCREEN_W - PLAT_W);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_CHECK, S_SCROLL} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q;
    logic [15:0]     lfsr_q;
    logic            sync1_q, sync2_q;
    logic [9:0]      snap_x_q, snap_y_q, snap_s_q, snap_vy_q;
    logic            hit_q;
    logic [9:0]      hit_y_q;
    logic            land_q, busy_q, pix_q;
    logic [9:0]      land_y_q, amt_q;
    logic [15:0]     score_q;
    logic [9:0]      px_q [NUM_PLAT];
    logic [9:0]      py_q [NUM_PLAT];

    logic            edge_s, last_s, cur_hit_s, wrap_s, vy_pos_s, pix_s;
    logic [9:0]      cur_x_s, cur_y_s, rand_x_s, new_amt_s, new_y_s;
    logic [10:0]     rx_s, sum_x_s, left_s, foot_s, cx_s, cy_s, moved_s;
    logic [16:0]     score_sum_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Per-index datapath: random X, landing test and scroll arithmetic (11-bit, no wrap).
    always_comb begin
        edge_s    = sync1_q & ~sync2_q;
        last_s    = (idx_q == IW'(NUM_PLAT - 1));
        rx_s      = {1'b0, lfsr_q[9:0]};
        rand_x_s  = (rx_s > X_SPAN) ? 10'(rx_s - X_SPAN) : rx_s[9:0];
        cur_x_s   = px_q[idx_q];
        cur_y_s   = py_q[idx_q];
        cx_s      = {1'b0, cur_x_s};
        cy_s      = {1'b0, cur_y_s};
        sum_x_s   = {1'b0, snap_x_q} + {1'b0, snap_s_q};
        left_s    = (snap_x_q >= snap_s_q) ? ({1'b0, snap_x_q} - {1'b0, snap_s_q}) : 11'd0;
        foot_s    = {1'b0, snap_y_q} + {1'b0, snap_s_q};
        vy_pos_s  = ~snap_vy_q[9] & (snap_vy_q != 10'd0);
        cur_hit_s = vy_pos_s & (sum_x_s > cx_s) & (left_s < cx_s + 11'(PLAT_W))
                  & (foot_s >= cy_s) & (foot_s < cy_s + 11'(PLAT_H));
        new_amt_s = (snap_y_q < 10'(SCROLL_LINE)) ? (10'(SCROLL_LINE) - snap_y_q) : 10'd0;
        moved_s   = cy_s + {1'b0, amt_q};
        wrap_s    = (moved_s >= 11'(SCREEN_H));
        new_y_s   = wrap_s ? 10'(moved_s - 11'(SCREEN_H)) : moved_s[9:0];
        score_sum_s = {1'b0, score_q} + {7'd0, amt_q};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = last_s ? S_IDLE : S_INIT;
            S_IDLE:   state_d = edge_s ? S_CHECK : S_IDLE;
            S_CHECK:  state_d = last_s ? S_SCROLL : S_CHECK;
            S_SCROLL: state_d = last_s ? S_IDLE : S_SCROLL;
            default:  state_d = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Control and result registers: sync, snapshot, landing, scroll amount, score.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q    <= SEED;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            idx_q     <= '0;
            snap_x_q  <= 10'd0;
            snap_y_q  <= 10'd0;
            snap_s_q  <= 10'd0;
            snap_vy_q <= 10'd0;
            hit_q     <= 1'b0;
            hit_y_q   <= 10'd0;
            land_q    <= 1'b0;
            land_y_q  <= 10'd0;
            amt_q     <= 10'd0;
            score_q   <= 16'd0;
            busy_q    <= 1'b1;
        end else begin
            lfsr_q  <= lfsr_step(lfsr_q);
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            land_q  <= 1'b0;
            busy_q  <= (state_d != S_IDLE);
            idx_q   <= ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : idx_q + IW'(1);
            case (state_q)
                S_IDLE: begin
                    if (edge_s) begin
                        snap_x_q  <= DoodleX;
                        snap_y_q  <= DoodleY;
                        snap_s_q  <= DoodleS;
                        snap_vy_q <= DoodleVY;
                        hit_q     <= 1'b0;
                    end
                end
                S_CHECK: begin
                    // Lowest index wins: later hits never overwrite hit_y_q.
                    if (cur_hit_s && !hit_q) begin
                        hit_q   <= 1'b1;
                        hit_y_q <= cur_y_s - snap_s_q;
                    end
                    if (last_s) begin
                        land_q <= hit_q | cur_hit_s;
                        amt_q  <= new_amt_s;
                        if (hit_q) begin
                            land_y_q <= hit_y_q;
                        end else if (cur_hit_s) begin
                            land_y_q <= cur_y_s - snap_s_q;
                        end
                    end
                end
                S_SCROLL: begin
                    if (last_s) begin
                        score_q <= score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Platform pool: evenly spaced layout in INIT, shifted and respawned in SCROLL.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                px_q[i] <= 10'd0;
                py_q[i] <= 10'd0;
            end
        end else begin
            case (state_q)
                S_INIT: begin
                    px_q[idx_q] <= rand_x_s;
                    py_q[idx_q] <= 10'(int'(idx_q) * (SCREEN_H / NUM_PLAT));
                end
                S_SCROLL: begin
                    py_q[idx_q] <= new_y_s;
                    if (wrap_s) begin
                        px_q[idx_q] <= rand_x_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel-inside-any-platform test.
    always_comb begin
        pix_s = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            pix_s = pix_s
                  | (({1'b0, DrawX} >= {1'b0, px_q[i]}) & ({1'b0, DrawX} < {1'b0, px_q[i]} + 11'(PLAT_W))
                   & ({1'b0, DrawY} >= {1'b0, py_q[i]}) & ({1'b0, DrawY} < {1'b0, py_q[i]} + 11'(PLAT_H)));
        end
    end

    // Registered pixel hit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_q <= 1'b0;
        end else begin
            pix_q <= pix_s;
        end
    end

    assign plat_pixel = pix_q;
    assign land       = land_q;
    assign land_y     = land_y_q;
    assign scroll_amt = amt_q;
    assign score      = score_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_platform_manager.sv
// Directed bench for platform_manager with a small spec-level model of layout, LFSR and score.
module tb_platform_manager;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  dx = 10'd0, dy = 10'd0, ds = 10'd0, dvy = 10'd0, drx = 10'd0, dry = 10'd0;
    logic        plat_pixel, land, busy;
    logic [9:0]  land_y, scroll_amt;
    logic [15:0] score;

    int total = 0;
    int bad   = 0;

    logic [15:0] lm;
    logic [15:0] hist [20];
    int          mx [8];
    int          my [8];
    int          score_m = 0;
    int          land_y_m = 0;

    platform_manager dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk),
        .DoodleX(dx), .DoodleY(dy), .DoodleS(ds), .DoodleVY(dvy),
        .DrawX(drx), .DrawY(dry),
        .plat_pixel(plat_pixel), .land(land), .land_y(land_y),
        .scroll_amt(scroll_amt), .score(score), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int randx(input logic [15:0] v);
        int r;
        r = int'(v[9:0]);
        return (r > 576) ? r - 576 : r;
    endfunction

    // Reference LFSR, free-running like the spec says.
    always @(posedge clk) begin
        if (rst) lm <= 16'hACE1;
        else     lm <= step(lm);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic init_model();
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < 8; i++) begin
            mx[i] = randx(l);
            my[i] = i * 60;
            l = step(l);
        end
    endtask

    function automatic bit model_pix(input int x, input int y);
        bit r;
        r = 1'b0;
        for (int i = 0; i < 8; i++)
            if (x >= mx[i] && x < mx[i] + 64 && y >= my[i] && y < my[i] + 8) r = 1'b1;
        return r;
    endfunction

    function automatic bit model_hit(input int x, input int y, input int s, input int vy, input int i);
        int left;
        left = (x >= s) ? x - s : 0;
        return (vy > 0) && (x + s > mx[i]) && (left < mx[i] + 64)
            && (y + s >= my[i]) && (y + s < my[i] + 8);
    endfunction

    task automatic pix(input string tag, input int x, input int y);
        @(negedge clk);
        drx = 10'(x);
        dry = 10'(y);
        @(posedge clk);
        @(negedge clk);
        chk(tag, {31'd0, plat_pixel}, {31'd0, model_pix(x, y)});
    endtask

    task automatic corners(input string tag);
        for (int i = 0; i < 8; i++) begin
            pix(tag, mx[i], my[i]);
            pix(tag, mx[i] + 63, my[i] + 7);
            pix(tag, mx[i] + 64, my[i] + 8);
        end
    endtask

    // One frame: pulse frame_clk, watch 20 cycles, then update the model.
    task automatic frame(input int x, input int y, input int s, input int vy, input bit extra);
        int  land_cnt, land_at, amt, hit_i, ny;
        bit  found;
        land_cnt = 0;
        land_at  = -1;
        found    = 1'b0;
        hit_i    = 0;
        @(negedge clk);
        dx = 10'(x); dy = 10'(y); ds = 10'(s); dvy = 10'(vy);
        frame_clk = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            hist[c] = lm;
            if (land) begin
                land_cnt++;
                land_at = c;
            end
            if (c == 0)  chk("busy_edge", {31'd0, busy}, 32'd0);
            if (c == 1)  chk("busy_start", {31'd0, busy}, 32'd1);
            if (c == 16) chk("busy_last", {31'd0, busy}, 32'd1);
            if (c == 17) chk("busy_done", {31'd0, busy}, 32'd0);
            if (c == 19) chk("busy_idle", {31'd0, busy}, 32'd0);
            if (c == 2) frame_clk = 1'b0;
            if (extra && c == 3) frame_clk = 1'b1;
            if (extra && c == 5) frame_clk = 1'b0;
        end
        for (int i = 0; i < 8; i++)
            if (!found && model_hit(x, y, s, vy, i)) begin
                found = 1'b1;
                hit_i = i;
            end
        if (found) land_y_m = (my[hit_i] - s) & 1023;
        chk("land_cnt", land_cnt, found ? 32'd1 : 32'd0);
        if (found) chk("land_lat", land_at, 32'd9);
        chk("land_y", {22'd0, land_y}, land_y_m);
        amt = (y < 160) ? 160 - y : 0;
        for (int i = 0; i < 8; i++) begin
            ny = my[i] + amt;
            if (ny >= 480) begin
                ny = ny - 480;
                mx[i] = randx(hist[9 + i]);
            end
            my[i] = ny;
        end
        score_m = (score_m + amt > 65535) ? 65535 : score_m + amt;
        chk("scroll_amt", {22'd0, scroll_amt}, amt);
        chk("score", {16'd0, score}, score_m);
    endtask

    initial begin
        // Reset and INIT timing.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_land", {31'd0, land}, 32'd0);
        chk("rst_land_y", {22'd0, land_y}, 32'd0);
        chk("rst_amt", {22'd0, scroll_amt}, 32'd0);
        chk("rst_score", {16'd0, score}, 32'd0);
        chk("rst_pix", {31'd0, plat_pixel}, 32'd0);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("init_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("init_done", {31'd0, busy}, 32'd0);
        init_model();
        pix("p3_top", mx[3], 180);
        pix("p3_below", mx[3], 188);
        corners("init_layout");

        // Landing on platform 5 (Y=300) and its boundaries.
        frame(mx[5] + 20, 295, 8, 3, 1'b0);
        chk("land_y_292", {22'd0, land_y}, 32'd292);
        frame(mx[5] + 20, 292, 8, 3, 1'b0);
        frame(mx[5] + 20, 300, 8, 3, 1'b0);
        frame(mx[5], 300, 0, 3, 1'b0);
        frame(mx[5] + 1, 300, 0, 3, 1'b0);
        frame(mx[5] + 64, 300, 0, 3, 1'b0);
        frame(mx[5] + 20, 295, 8, -3, 1'b0);
        frame(mx[5] + 20, 295, 8, 0, 1'b0);

        // Scrolling, respawn at exactly SCREEN_H, dropped edge during CHECK.
        frame(0, 100, 8, -3, 1'b0);
        corners("scroll1");
        frame(0, 100, 8, -3, 1'b0);
        frame(0, 100, 8, -3, 1'b1);
        chk("score_180", {16'd0, score}, 32'd180);
        corners("scroll3");

        // Score saturation.
        while (score_m < 65535) frame(0, 0, 8, -3, 1'b0);
        frame(0, 100, 8, -3, 1'b0);
        chk("score_sat", {16'd0, score}, 32'hFFFF);

        // Reset while SCROLL handles index 4.
        @(negedge clk);
        dx = 10'd0; dy = 10'd100; ds = 10'd8; dvy = 10'(-3);
        frame_clk = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) frame_clk = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_score", {16'd0, score}, 32'd0);
        chk("mid_land", {31'd0, land}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_idle", {31'd0, busy}, 32'd0);
        init_model();
        score_m = 0;
        land_y_m = 0;
        corners("reinit_layout");
        frame(mx[5] + 20, 295, 8, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/platform_manager.md
Name: platform_manager

Overview:
Platform-state stage between jumplogic and color_mapper.
- Holds a fixed pool of platform rectangles.
- Once per frame (rising edge of frame_clk, i.e. VGA_VS): tests the doodle for landing, scrolls the world when the doodle climbs above a threshold, and respawns platforms that leave the bottom of the screen at random X.
- Feeds color_mapper a per-pixel platform hit, feeds jumplogic a landing pulse, and produces a climb score for the HEX path.

Parameters:
NUM_PLAT, 8, number of platforms (2..16)
PLAT_W, 64, platform width in pixels
PLAT_H, 8, platform height in pixels
SCROLL_LINE, 160, doodle Y above which the world scrolls
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  frame strobe (VGA_VS), asynchronous to frame timing, sampled on Clk
DoodleX  in  10  doodle centre X
DoodleY  in  10  doodle centre Y
DoodleS  in  10  doodle half-size
DoodleVY  in  10  doodle vertical velocity, two's complement, positive = falling
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
plat_pixel  out  1  registered: (DrawX,DrawY) from previous cycle lies inside a platform
land  out  1  one-cycle pulse: doodle landed this frame
land_y  out  10  corrected doodle centre Y on landing; held until next land
scroll_amt  out  10  pixels scrolled in last frame; held
score  out  16  cumulative scrolled pixels, saturating
busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Clk.
- Reset values: plat_pixel=0, land=0, land_y=0, scroll_amt=0, score=0, busy=1, LFSR=SEED, FSM=INIT, index=0.
- LFSR:
  - 16-bit Galois, mask 16'hB400, advances every Clk (including INIT).
  - Random X = lfsr[9:0]; if value > SCREEN_W-PLAT_W, subtract SCREEN_W-PLAT_W.
- Frame edge:
  - frame_clk is registered twice; edge = sync1 & ~sync2.
  - An edge arriving while busy=1 is dropped. No queueing.
- FSM states:
  - INIT: one platform per cycle, i=0..NUM_PLAT-1. Y_i = i*(SCREEN_H/NUM_PLAT); X_i = random X. Then go to IDLE. INIT takes NUM_PLAT cycles after reset deasserts.
  - IDLE: busy=0. On edge, latch DoodleX/Y/S/VY into snapshot registers, index=0, go to CHECK.
  - CHECK: one platform per cycle; uses snapshot values only.
    - Hit condition, all true: VY>0 (signed); X+S > X_i; X-S < X_i+PLAT_W; Y+S >= Y_i; Y+S < Y_i+PLAT_H.
    - First hit (lowest index) wins; later hits are ignored.
    - After the last index: if a hit occurred, land=1 for exactly one cycle and land_y = Y_i - S. Then go to SCROLL.
  - SCROLL:
    - amt = (snapY < SCROLL_LINE) ? SCROLL_LINE - snapY : 0. Computed once on entry; drives scroll_amt.
    - One platform per cycle: Y_i += amt.
    - If the result is >= SCREEN_H: Y_i = result - SCREEN_H and X_i = random X (respawn at top).
    - After the last index: score = min(score+amt, 16'hFFFF). Go to IDLE.
- Frame cost: NUM_PLAT (CHECK) + NUM_PLAT (SCROLL) + 1 cycles per frame (17 at default).
- Arithmetic widths:
  - All position maths in 11 bits unsigned, so Y_i + amt never wraps before the SCREEN_H compare.
  - X-S < 0 is treated as 0 (the left edge is clamped, not wrapped).
- plat_pixel:
  - Registered OR over i of (X_i <= DrawX < X_i+PLAT_W) & (Y_i <= DrawY < Y_i+PLAT_H).
  - Latency 1 Clk.
  - Reflects platform registers as they are mid-update; a partially scrolled frame appears for at most 17 cycles during blanking. This is accepted.
- Reset mid-operation: any FSM state goes to INIT next cycle; land cleared, score cleared, all platforms re-initialised.

Test Plan:
1. Reset 1 cycle, then release -> busy=1 for 8 cycles then 0; platform 3 at Y=180; X_i values are all <= 576; plat_pixel=1 at (X_3, 180), 0 at (X_3, 188).
2. Force platform 2 to X=100, Y=300; DoodleX=120, DoodleY=295, S=8, VY=+3; pulse frame_clk -> exactly one land pulse 9 cycles after edge detect, land_y=292.
3. Same geometry as scenario 2 but VY=-3 (or VY=0) -> no land pulse; land_y keeps its previous value.
4. DoodleY=100, no hit -> scroll_amt=60; every Y_i +60; platform at Y=450 becomes Y=30 with new X; score 0 -> 60; two more frames -> score=180.
5. score preset to 16'hFFF0, amt=60 -> score=16'hFFFF; frame_clk pulse during CHECK -> ignored, no second pass.
6. Reset asserted in SCROLL at index 4 -> next cycle state INIT, score=0, land=0; after 8 cycles layout matches scenario 1 for the same SEED.
